// File: rtl/lru_evict_drain.sv
// rtl/lru_evict_drain.sv - LRU queue consumer: pops head on evict/flush, writes back dirty lines.
// Pops are folded into IDLE and DONE so a flush drains back-to-back entries without bubbles.
module lru_evict_drain #(
  parameter int DATAW      = 64,
  parameter int LINE_ADDRW = 26,
  parameter int CNTW       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        q_empty,
  input  logic [DATAW-1:0]            q_data,
  output logic                        q_pop,
  input  logic                        evict_valid,
  input  logic                        flush_valid,
  output logic                        cmd_ready,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic [LINE_ADDRW-1:0]       mem_req_addr,
  output logic [DATAW-2-LINE_ADDRW:0] mem_req_data,
  input  logic                        mem_rsp_valid,
  output logic                        done_valid,
  output logic [1:0]                  done_status,
  output logic [LINE_ADDRW-1:0]       done_addr,
  output logic                        flush_done,
  output logic                        busy,
  output logic [CNTW-1:0]             wb_count
);

  localparam int PAYW = DATAW - 1 - LINE_ADDRW;

  typedef enum logic [2:0] {IDLE, POP, WB_REQ, WB_WAIT, DONE, FDONE} state_t;

  state_t              state_q;
  logic [DATAW-2:0]    entry_q;
  logic                flush_q;
  logic [1:0]          status_q;
  logic [CNTW-1:0]     cnt_q;

  logic idle;
  logic take_cmd;
  logic chain_pop;

  assign idle      = (state_q == IDLE);
  assign take_cmd  = idle && (flush_valid || evict_valid);
  assign chain_pop = (state_q == DONE) && flush_q && !q_empty;

  // Gated by reset so nothing is accepted or popped while the block is held in reset
  assign cmd_ready = reset && idle;
  assign q_pop     = reset && ((take_cmd && !q_empty) || chain_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      entry_q  <= '0;
      flush_q  <= 1'b0;
      status_q <= 2'b00;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_valid || evict_valid) begin
            flush_q <= flush_valid;
            if (q_empty) begin
              entry_q  <= '0;
              status_q <= 2'b10;
              state_q  <= flush_valid ? FDONE : DONE;
            end else begin
              entry_q <= q_data[DATAW-2:0];
              if (q_data[DATAW-1]) begin
                state_q <= WB_REQ;
              end else begin
                status_q <= 2'b00;
                state_q  <= DONE;
              end
            end
          end
        end
        WB_REQ: begin
          if (mem_req_ready) state_q <= WB_WAIT;
        end
        WB_WAIT: begin
          if (mem_rsp_valid) begin
            if (cnt_q != '1) cnt_q <= cnt_q + CNTW'(1);
            status_q <= 2'b01;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (flush_q && !q_empty) begin
            entry_q <= q_data[DATAW-2:0];
            if (q_data[DATAW-1]) begin
              state_q <= WB_REQ;
            end else begin
              status_q <= 2'b00;
              state_q  <= DONE;
            end
          end else if (flush_q) begin
            state_q <= FDONE;
          end else begin
            state_q <= IDLE;
          end
        end
        FDONE: begin
          flush_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = !idle;
  assign mem_req_valid = (state_q == WB_REQ);
  assign mem_req_addr  = entry_q[DATAW-2 -: LINE_ADDRW];
  assign mem_req_data  = entry_q[PAYW-1:0];
  assign done_valid    = (state_q == DONE);
  assign done_status   = status_q;
  assign done_addr     = entry_q[DATAW-2 -: LINE_ADDRW];
  assign flush_done    = (state_q == FDONE);
  assign wb_count      = cnt_q;

  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset) !(q_pop && q_empty));
  a_no_early_rsp: assert property (@(posedge clk) disable iff (!reset) !((state_q == WB_REQ) && mem_rsp_valid));

endmodule

// File: tb/tb_lru_evict_drain.sv
// tb/tb_lru_evict_drain.sv - directed bench for lru_evict_drain with a queue model and memory responder.
module tb_lru_evict_drain;
  localparam int DATAW = 64;
  localparam int LAW   = 26;
  localparam int PAYW  = DATAW - 1 - LAW;
  localparam int CNTW  = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             q_empty = 1'b1;
  logic [DATAW-1:0] q_data = '0;
  logic             q_pop;
  logic             evict_valid = 1'b0;
  logic             flush_valid = 1'b0;
  logic             cmd_ready;
  logic             mem_req_valid;
  logic             mem_req_ready = 1'b0;
  logic [LAW-1:0]   mem_req_addr;
  logic [PAYW-1:0]  mem_req_data;
  logic             mem_rsp_valid = 1'b0;
  logic             done_valid;
  logic [1:0]       done_status;
  logic [LAW-1:0]   done_addr;
  logic             flush_done;
  logic             busy;
  logic [CNTW-1:0]  wb_count;

  logic [DATAW-1:0] qm[$];
  logic             auto_rsp = 1'b0;
  int               n_chk = 0;
  int               n_pass = 0;

  lru_evict_drain #(.DATAW(DATAW), .LINE_ADDRW(LAW), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .q_empty(q_empty), .q_data(q_data), .q_pop(q_pop),
    .evict_valid(evict_valid), .flush_valid(flush_valid), .cmd_ready(cmd_ready),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_rsp_valid(mem_rsp_valid), .done_valid(done_valid), .done_status(done_status),
    .done_addr(done_addr), .flush_done(flush_done), .busy(busy), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [DATAW-1:0] mk(input logic dirty, input logic [LAW-1:0] a,
                                          input logic [PAYW-1:0] p);
    return {dirty, a, p};
  endfunction

  task automatic refresh();
    q_empty = (qm.size() == 0);
    q_data  = q_empty ? '0 : qm[0];
  endtask

  // One clock: sample pop/handshake mid-cycle, then update queue model and responder after the edge
  task automatic cyc();
    logic p, hs;
    @(negedge clk);
    p  = q_pop;
    hs = mem_req_valid && mem_req_ready;
    @(posedge clk);
    #1;
    if (p && qm.size() > 0) void'(qm.pop_front());
    if (auto_rsp) mem_rsp_valid = hs;
    refresh();
  endtask

  task automatic do_evict(input logic [1:0] st, input logic [LAW-1:0] a);
    evict_valid = 1'b1;
    cyc();
    evict_valid = 1'b0;
    for (int i = 0; i < 20 && !done_valid; i++) cyc();
    chk("ev_done", done_valid, 1);
    chk("ev_status", done_status, st);
    chk("ev_addr", done_addr, a);
    cyc();
  endtask

  initial begin
    logic [1:0]     st[4];
    logic [LAW-1:0] ad[4];
    int ndone, nfd, fd_after;

    refresh();
    cyc(); cyc();
    reset = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done_valid, 0);
    chk("rst_memv", mem_req_valid, 0);
    chk("rst_wb", wb_count, 0);
    chk("rst_fdone", flush_done, 0);
    chk("rst_cmd_ready", cmd_ready, 1);

    // clean evict
    qm.push_back(mk(1'b0, 26'h123, 37'h5)); refresh();
    evict_valid = 1'b1;
    #1;
    chk("clean_pop", q_pop, 1);
    cyc();
    evict_valid = 1'b0;
    chk("clean_done", done_valid, 1);
    chk("clean_status", done_status, 2'b00);
    chk("clean_addr", done_addr, 26'h123);
    chk("clean_wb", wb_count, 0);
    chk("clean_qsize", qm.size(), 0);
    cyc();
    chk("clean_idle", busy, 0);

    // dirty evict with ready stall then delayed ack
    qm.push_back(mk(1'b1, 26'h2A, 37'h1234)); refresh();
    evict_valid = 1'b1;
    cyc();
    evict_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("dirty_reqv", mem_req_valid, 1);
      chk("dirty_addr_stall", mem_req_addr, 26'h2A);
      chk("dirty_data_stall", mem_req_data, 37'h1234);
      cyc();
    end
    mem_req_ready = 1'b1;
    #1;
    chk("dirty_addr_hs", mem_req_addr, 26'h2A);
    cyc();
    mem_req_ready = 1'b0;
    chk("dirty_wait_reqv", mem_req_valid, 0);
    chk("dirty_wait_busy", busy, 1);
    cyc();
    mem_rsp_valid = 1'b1;
    cyc();
    mem_rsp_valid = 1'b0;
    chk("dirty_done", done_valid, 1);
    chk("dirty_status", done_status, 2'b01);
    chk("dirty_addr", done_addr, 26'h2A);
    chk("dirty_wb", wb_count, 1);
    cyc();

    // evict on empty queue
    evict_valid = 1'b1;
    #1;
    chk("empty_pop", q_pop, 0);
    cyc();
    evict_valid = 1'b0;
    chk("empty_done", done_valid, 1);
    chk("empty_status", done_status, 2'b10);
    cyc();

    // flush of dirty, clean, dirty, clean
    qm.push_back(mk(1'b1, 26'h10, 37'h1));
    qm.push_back(mk(1'b0, 26'h11, 37'h2));
    qm.push_back(mk(1'b1, 26'h12, 37'h3));
    qm.push_back(mk(1'b0, 26'h13, 37'h4));
    refresh();
    mem_req_ready = 1'b1;
    auto_rsp = 1'b1;
    flush_valid = 1'b1;
    cyc();
    flush_valid = 1'b0;
    ndone = 0; nfd = 0; fd_after = 0;
    for (int i = 0; i < 40 && nfd == 0; i++) begin
      if (done_valid) begin
        if (ndone < 4) begin st[ndone] = done_status; ad[ndone] = done_addr; end
        ndone++;
      end
      if (flush_done) begin nfd++; fd_after = (ndone == 4); end
      cyc();
    end
    auto_rsp = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;
    chk("flush_ndone", ndone, 4);
    chk("flush_nfdone", nfd, 1);
    chk("flush_fd_last", fd_after, 1);
    chk("flush_st0", st[0], 2'b01); chk("flush_ad0", ad[0], 26'h10);
    chk("flush_st1", st[1], 2'b00); chk("flush_ad1", ad[1], 26'h11);
    chk("flush_st2", st[2], 2'b01); chk("flush_ad2", ad[2], 26'h12);
    chk("flush_st3", st[3], 2'b00); chk("flush_ad3", ad[3], 26'h13);
    chk("flush_wb", wb_count, 3);
    chk("flush_busy", busy, 0);

    // flush and evict together: flush wins, evict stalls until IDLE
    qm.push_back(mk(1'b0, 26'h20, 37'h0));
    qm.push_back(mk(1'b0, 26'h21, 37'h0));
    refresh();
    flush_valid = 1'b1; evict_valid = 1'b1;
    cyc();
    flush_valid = 1'b0;
    chk("both_addr0", done_addr, 26'h20);
    chk("both_stall0", cmd_ready, 0);
    cyc();
    chk("both_addr1", done_addr, 26'h21);
    chk("both_stall1", cmd_ready, 0);
    cyc();
    chk("both_fdone", flush_done, 1);
    chk("both_stall2", cmd_ready, 0);
    cyc();
    chk("both_accept", cmd_ready, 1);
    cyc();
    evict_valid = 1'b0;
    chk("both_ev_done", done_valid, 1);
    chk("both_ev_status", done_status, 2'b10);
    cyc();

    // reset during WB_WAIT, then a late ack
    qm.push_back(mk(1'b1, 26'h33, 37'h7)); refresh();
    mem_req_ready = 1'b1;
    evict_valid = 1'b1;
    cyc();
    evict_valid = 1'b0;
    cyc();
    mem_req_ready = 1'b0;
    chk("rw_busy", busy, 1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    #1;
    chk("rw_idle", busy, 0);
    chk("rw_reqv", mem_req_valid, 0);
    chk("rw_addr", mem_req_addr, 0);
    chk("rw_done", done_valid, 0);
    chk("rw_status", done_status, 0);
    chk("rw_wb", wb_count, 0);
    mem_rsp_valid = 1'b1;
    cyc();
    mem_rsp_valid = 1'b0;
    chk("rw_late_wb", wb_count, 0);
    chk("rw_late_done", done_valid, 0);
    chk("rw_late_busy", busy, 0);

    // saturation of the writeback counter
    mem_req_ready = 1'b1;
    auto_rsp = 1'b1;
    for (int k = 0; k < 16; k++) begin
      qm.push_back(mk(1'b1, 26'(k + 64), 37'(k))); refresh();
      do_evict(2'b01, 26'(k + 64));
      if (k == 14) chk("sat_pre", wb_count, 4'hF);
    end
    chk("sat_hold", wb_count, 4'hF);
    auto_rsp = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
